m_imem_loader: RTL

Program loader that writes the instruction memory the processor fetches from. It accepts a byte stream (typically from a UART receiver), assembles little-endian 32-bit words and issues one write per word to the imem write port. While loading, it holds the processor in reset and releases it once an image with a valid checksum has been written. It sits between the host byte link and the imem write side; the processor fetch side of the imem is untouched.

---
 rtl/m_imem_loader_pkg.sv | 15 +
 rtl/m_imem_loader_word_asm.sv | 39 +++
 rtl/m_imem_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/m_imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and frame constants.
package m_imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_SUM  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/m_imem_loader_word_asm.sv
// Little-endian 4-byte assembler: the first strobed byte lands in bits [7:0].
// word_ready and word are combinational on the strobe of the 4th byte so the
// parent can register them with a single cycle of latency.
module m_word_asm
  import m_imem_loader_pkg::*;
(
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_clr,
  input  logic [7:0]  w_byte,
  input  logic        w_strobe,
  output logic [31:0] w_word,
  output logic        w_word_ready
);

  logic [1:0]  cnt_r;
  logic [23:0] shift_r;

  // Combine the three held bytes with the incoming top byte.
  always_comb begin
    w_word       = {w_byte, shift_r};
    w_word_ready = w_strobe && (cnt_r == 2'(BYTES_PER_WORD - 1));
  end

  // Shift bytes in from the top and count position within the word.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      cnt_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (w_clr) begin
      cnt_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (w_strobe) begin
      cnt_r   <= cnt_r + 2'd1;
      shift_r <= {w_byte, shift_r[23:8]};
    end
  end

endmodule

// File: rtl/m_imem_loader.sv
// Program loader: parses a header/payload/checksum byte frame, writes words to
// imem, and holds the CPU in reset until a checksum-verified image is present.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic [7:0]  w_rx_data,
  input  logic        w_rx_valid,
  output logic        w_rx_ready,
  input  logic        w_reload,
  output logic        w_we,
  output logic [31:0] w_waddr,
  output logic [31:0] w_wdata,
  output logic        w_cpu_rst,
  output logic        w_done,
  output logic        w_err
);

  state_t      state_r, state_s;
  logic [1:0]  hdr_cnt_r;
  logic [31:0] n_r, word_cnt_r;
  logic [7:0]  xor_r;
  logic        we_r, done_r, err_r, cpu_rst_r, rx_ready_r;
  logic [31:0] waddr_r, wdata_r;

  logic        xfer_s, reload_s, asm_strobe_s, word_ready_s;
  logic [31:0] word_s, n_next_s;

  assign w_rx_ready   = rx_ready_r;
  assign w_we         = we_r;
  assign w_waddr      = waddr_r;
  assign w_wdata      = wdata_r;
  assign w_cpu_rst    = cpu_rst_r;
  assign w_done       = done_r;
  assign w_err        = err_r;

  assign xfer_s       = w_rx_valid && rx_ready_r;
  assign reload_s     = w_reload && ((state_r == ST_DONE) || (state_r == ST_ERR));
  assign asm_strobe_s = xfer_s && (state_r == ST_DATA);
  assign n_next_s     = {w_rx_data, n_r[31:8]};

  m_word_asm u_word_asm (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_clr        (reload_s),
    .w_byte       (w_rx_data),
    .w_strobe     (asm_strobe_s),
    .w_word       (word_s),
    .w_word_ready (word_ready_s)
  );

  // Next-state logic for the frame parser.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (xfer_s && (hdr_cnt_r == 2'(HDR_BYTES - 1))) begin
          if (n_next_s > 32'(DEPTH_WORDS)) begin
            state_s = ST_ERR;
          end else if (n_next_s == 32'd0) begin
            state_s = ST_SUM;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (word_ready_s && ((word_cnt_r + 32'd1) == n_r)) begin
          state_s = ST_SUM;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_SUM: begin
        if (xfer_s) begin
          state_s = (w_rx_data == xor_r) ? ST_DONE : ST_ERR;
        end else begin
          state_s = ST_SUM;
        end
      end
      ST_DONE, ST_ERR: begin
        if (reload_s) begin
          state_s = ST_HDR;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_HDR;
    endcase
  end

  // State register.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_s;
    end
  end

  // Header count, word counter, running XOR, imem write port and status flags.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      hdr_cnt_r  <= 2'd0;
      n_r        <= 32'd0;
      word_cnt_r <= 32'd0;
      xor_r      <= 8'd0;
      we_r       <= 1'b0;
      waddr_r    <= 32'd0;
      wdata_r    <= 32'd0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      cpu_rst_r  <= 1'b1;
      rx_ready_r <= 1'b1;
    end else begin
      we_r <= 1'b0;
      if ((state_r == ST_HDR) && xfer_s) begin
        n_r       <= n_next_s;
        hdr_cnt_r <= hdr_cnt_r + 2'd1;
      end
      if (asm_strobe_s) begin
        xor_r <= xor_r ^ w_rx_data;
      end
      if (word_ready_s) begin
        we_r       <= 1'b1;
        wdata_r    <= word_s;
        waddr_r    <= {word_cnt_r[29:0], 2'b00};
        word_cnt_r <= word_cnt_r + 32'd1;
      end
      if (reload_s) begin
        hdr_cnt_r  <= 2'd0;
        n_r        <= 32'd0;
        word_cnt_r <= 32'd0;
        xor_r      <= 8'd0;
        waddr_r    <= 32'd0;
      end
      done_r     <= (state_s == ST_DONE);
      err_r      <= (state_s == ST_ERR);
      cpu_rst_r  <= (state_s != ST_DONE);
      rx_ready_r <= (state_s == ST_HDR) || (state_s == ST_DATA) || (state_s == ST_SUM);
    end
  end

endmodule
